// File: rtl/wb_timer_pkg.sv
// wb_timer_pkg: shared constants and helpers for the wb_timer peripheral.
//   - Register word addresses (bus adr[4:2]).
//   - CTRL bit positions.
//   - Reset value of the 64-bit compare register.
//   - byte_merge(): applies Wishbone byte enables to a 32-bit register word.
package wb_timer_pkg;

  localparam logic [2:0] ADDR_MTIME_LO    = 3'd0;
  localparam logic [2:0] ADDR_MTIME_HI    = 3'd1;
  localparam logic [2:0] ADDR_MTIMECMP_LO = 3'd2;
  localparam logic [2:0] ADDR_MTIMECMP_HI = 3'd3;
  localparam logic [2:0] ADDR_CTRL        = 3'd4;
  localparam logic [2:0] ADDR_PRESCALE    = 3'd5;
  localparam logic [2:0] ADDR_STATUS      = 3'd6;
  localparam logic [2:0] ADDR_UNMAPPED    = 3'd7;

  localparam int CTRL_EN = 0;
  localparam int CTRL_IE = 1;

  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/wb_timer_prescaler.sv
// wb_timer_prescaler: divides the clock by (i_prescale+1) while enabled.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_en           count enable; counter holds while low
//   i_prescale     terminal count; a tick is produced when the counter equals it
//   i_clr          restart the count from zero (register write to CTRL/PRESCALE)
//   o_tick         one-cycle pulse, combinational from the current count
module wb_timer_prescaler
  import wb_timer_pkg::*;
#(
  parameter int PRESCALE_W = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic [PRESCALE_W-1:0] i_prescale,
  input  logic                  i_clr,
  output logic                  o_tick
);

  logic [PRESCALE_W-1:0] r_pcnt;
  logic                  w_match;

  assign w_match = (r_pcnt == i_prescale);
  // The tick reflects the state before any clear in this cycle, so a
  // CTRL/PRESCALE write that lands on a terminal count still counts it.
  assign o_tick  = i_en & w_match;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pcnt <= '0;
    end else if (i_clr) begin
      r_pcnt <= '0;
    end else if (i_en) begin
      r_pcnt <= w_match ? '0 : r_pcnt + {{(PRESCALE_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/wb_timer.sv
// wb_timer: Wishbone B3 classic slave with a 64-bit mtime counter, a 64-bit
// mtimecmp compare register and a level timer interrupt.
// Ports:
//   wb_clk_i, wb_rst_i    clock, synchronous active-high reset
//   wb_adr_i              word address (bus adr[4:2])
//   wb_dat_i, wb_sel_i    write data and byte enables
//   wb_we_i, wb_cyc_i, wb_stb_i   classic-cycle handshake inputs
//   wb_cti_i, wb_bte_i    burst hints, ignored (every beat is classic)
//   wb_dat_o              read data, valid while wb_ack_o is high
//   wb_ack_o, wb_err_o    one-cycle registered acknowledge / error
//   timer_irq_o           registered IE & (mtime >= mtimecmp)
module wb_timer
  import wb_timer_pkg::*;
#(
  parameter int PRESCALE_W     = 16,
  parameter int PRESCALE_RESET = 0
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [2:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic [2:0]  wb_cti_i,
  input  logic [1:0]  wb_bte_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        timer_irq_o
);

  logic [63:0]           r_mtime;
  logic [63:0]           r_mtimecmp;
  logic [31:0]           r_shadow;
  logic [1:0]            r_ctrl;
  logic [PRESCALE_W-1:0] r_prescale;
  logic                  r_ack;
  logic                  r_err;
  logic [31:0]           r_dat;
  logic                  r_irq;

  logic                  w_req;
  logic                  w_wr;
  logic                  w_rd;
  logic                  w_tick;
  logic                  w_cmp;
  logic                  w_pclr;
  logic [31:0]           w_rdata;
  logic [63:0]           w_mtime_nxt;
  logic [PRESCALE_W-1:0] w_prescale_wr;
  logic                  w_unused;

  assign w_unused = ^{wb_cti_i, wb_bte_i};

  // A new beat is accepted only when no ack/err is being presented, which
  // limits a held strobe to one transfer every two cycles.
  assign w_req  = wb_cyc_i & wb_stb_i & ~r_ack & ~r_err;
  assign w_wr   = w_req & wb_we_i;
  assign w_rd   = w_req & ~wb_we_i;
  assign w_cmp  = (r_mtime >= r_mtimecmp);
  assign w_pclr = w_wr & ((wb_adr_i == ADDR_CTRL) | (wb_adr_i == ADDR_PRESCALE));

  wb_timer_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .i_clk      (wb_clk_i),
    .i_rst      (wb_rst_i),
    .i_en       (r_ctrl[CTRL_EN]),
    .i_prescale (r_prescale),
    .i_clr      (w_pclr),
    .o_tick     (w_tick)
  );

  always_comb begin
    w_rdata = '0;
    case (wb_adr_i)
      ADDR_MTIME_LO:    w_rdata = r_mtime[31:0];
      ADDR_MTIME_HI:    w_rdata = r_shadow;
      ADDR_MTIMECMP_LO: w_rdata = r_mtimecmp[31:0];
      ADDR_MTIMECMP_HI: w_rdata = r_mtimecmp[63:32];
      ADDR_CTRL:        w_rdata = {30'd0, r_ctrl};
      ADDR_PRESCALE:    w_rdata = 32'(r_prescale);
      ADDR_STATUS:      w_rdata = {30'd0, r_irq, w_cmp};
      default:          w_rdata = '0;
    endcase
  end

  always_comb begin
    w_prescale_wr = r_prescale;
    for (int b = 0; b < PRESCALE_W; b++) begin
      if (wb_sel_i[b/8]) w_prescale_wr[b] = wb_dat_i[b];
    end
  end

  // A bus write to either half overrides a coincident tick; the other half
  // keeps its pre-tick value, so no carry crosses the halves.
  always_comb begin
    w_mtime_nxt = r_mtime;
    if (w_tick) w_mtime_nxt = r_mtime + 64'd1;
    if (w_wr && (wb_adr_i == ADDR_MTIME_LO)) begin
      w_mtime_nxt = {r_mtime[63:32], byte_merge(r_mtime[31:0], wb_dat_i, wb_sel_i)};
    end else if (w_wr && (wb_adr_i == ADDR_MTIME_HI)) begin
      w_mtime_nxt = {byte_merge(r_mtime[63:32], wb_dat_i, wb_sel_i), r_mtime[31:0]};
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_mtime    <= '0;
      r_mtimecmp <= MTIMECMP_RST;
      r_shadow   <= '0;
      r_ctrl     <= '0;
      r_prescale <= PRESCALE_W'(PRESCALE_RESET);
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_dat      <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_mtime <= w_mtime_nxt;
      r_irq   <= r_ctrl[CTRL_IE] & w_cmp;
      r_ack   <= w_req & (wb_adr_i != ADDR_UNMAPPED);
      r_err   <= w_req & (wb_adr_i == ADDR_UNMAPPED);
      r_dat   <= (w_rd && (wb_adr_i != ADDR_UNMAPPED)) ? w_rdata : 32'd0;

      // Capture the high word alongside a low-word read for atomic 64-bit reads.
      if (w_rd && (wb_adr_i == ADDR_MTIME_LO)) r_shadow <= r_mtime[63:32];

      if (w_wr) begin
        case (wb_adr_i)
          ADDR_MTIMECMP_LO: r_mtimecmp[31:0]  <= byte_merge(r_mtimecmp[31:0], wb_dat_i, wb_sel_i);
          ADDR_MTIMECMP_HI: r_mtimecmp[63:32] <= byte_merge(r_mtimecmp[63:32], wb_dat_i, wb_sel_i);
          ADDR_CTRL:        r_ctrl <= wb_sel_i[0] ? wb_dat_i[1:0] : r_ctrl;
          ADDR_PRESCALE:    r_prescale <= w_prescale_wr;
          default:          ;
        endcase
      end
    end
  end

  assign wb_dat_o    = r_dat;
  assign wb_ack_o    = r_ack;
  assign wb_err_o    = r_err;
  assign timer_irq_o = r_irq;

endmodule

// File: tb/tb_wb_timer.sv
module tb_wb_timer;

  logic        clk;
  logic        rst;
  logic [2:0]  adr;
  logic [31:0] dat_i;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [31:0] dat_o;
  logic        ack;
  logic        err;
  logic        irq;

  int     checks = 0;
  int     errors = 0;
  longint ncyc = 0;
  longint last_edge = 0;

  wb_timer #(.PRESCALE_W(16), .PRESCALE_RESET(0)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wb_adr_i    (adr),
    .wb_dat_i    (dat_i),
    .wb_sel_i    (sel),
    .wb_we_i     (we),
    .wb_cyc_i    (cyc),
    .wb_stb_i    (stb),
    .wb_cti_i    (cti),
    .wb_bte_i    (bte),
    .wb_dat_o    (dat_o),
    .wb_ack_o    (ack),
    .wb_err_o    (err),
    .timer_irq_o (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) ncyc <= ncyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One classic beat: drive after an edge, request sampled at the next edge
  // (recorded in last_edge), response sampled 1 time unit later, then the
  // response must be gone one cycle after that.
  task automatic bus(input logic [2:0] a, input logic w, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rd_v,
                     output logic ack_v, output logic err_v);
    @(posedge clk); #1;
    chk("ack_before_req", {62'd0, ack, err}, 64'd0);
    adr = a; we = w; dat_i = d; sel = s; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    last_edge = ncyc;
    rd_v = dat_o; ack_v = ack; err_v = err;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    chk("ack_width", {62'd0, ack, err}, 64'd0);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    logic [31:0] r; logic k, e;
    bus(a, 1'b1, d, 4'hF, r, k, e);
    chk("wr_ack", {62'd0, k, e}, 64'd2);
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] v);
    logic k, e;
    bus(a, 1'b0, 32'd0, 4'hF, v, k, e);
    chk("rd_ack", {62'd0, k, e}, 64'd2);
  endtask

  // Reference: mtime value held in the register just before edge r, when the
  // counter was loaded with base and enabled at edge e with period p+1.
  function automatic logic [63:0] mt_at(input logic [63:0] base, input longint e,
                                        input longint r, input int p);
    return base + 64'((r - 1 - e) / (p + 1));
  endfunction

  initial begin
    logic [31:0] v, v2;
    logic        k, e;
    logic [31:0] rst_exp [7];
    logic [63:0] base, expv, pre;
    longint      en_edge, w_edge;
    int          p, wt;

    rst = 1'b1; adr = '0; dat_i = '0; sel = '0; we = 1'b0; cyc = 1'b0; stb = 1'b0;
    cti = 3'd0; bte = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {28'd0, dat_o, ack, err, irq, 1'b0}, 64'd0);
    rst = 1'b0;

    // Reset register values
    rst_exp = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0};
    for (int i = 0; i < 7; i++) begin
      rd(3'(i), v);
      chk($sformatf("rst_reg%0d", i), {32'd0, v}, {32'd0, rst_exp[i]});
    end
    bus(3'd7, 1'b0, 32'd0, 4'hF, v, k, e);
    chk("unmapped_rd_resp", {62'd0, k, e}, 64'd1);
    chk("unmapped_rd_data", {32'd0, v}, 64'd0);
    bus(3'd7, 1'b1, 32'hDEAD_BEEF, 4'hF, v, k, e);
    chk("unmapped_wr_resp", {62'd0, k, e}, 64'd1);
    wr(3'd6, 32'hFFFF_FFFF);
    rd(3'd6, v);
    chk("status_ro", {32'd0, v}, 64'd0);
    wr(3'd5, 32'h0001_2345);
    rd(3'd5, v);
    chk("prescale_width", {32'd0, v}, 64'h2345);

    // PRESCALE=3: 40 cycles of counting gives 10 increments
    wr(3'd4, 32'd0); wr(3'd5, 32'd3); wr(3'd0, 32'd0); wr(3'd1, 32'd0);
    wr(3'd4, 32'd1); en_edge = last_edge;
    repeat (38) @(posedge clk);
    rd(3'd0, v);
    chk("presc3_model", {32'd0, v}, mt_at(64'd0, en_edge, last_edge, 3));
    chk("presc3_ten", {32'd0, v}, 64'd10);

    // Wrap through zero with atomic LO->HI reads
    base = 64'hFFFF_FFFF_FFFF_FFFD;
    wr(3'd4, 32'd0); wr(3'd5, 32'd0); wr(3'd0, base[31:0]); wr(3'd1, base[63:32]);
    wr(3'd4, 32'd1); en_edge = last_edge;
    for (int j = 0; j < 2; j++) begin
      rd(3'd0, v);  expv = mt_at(base, en_edge, last_edge, 0);
      rd(3'd1, v2);
      chk($sformatf("wrap_lo%0d", j), {32'd0, v}, {32'd0, expv[31:0]});
      chk($sformatf("wrap_hi%0d", j), {32'd0, v2}, {32'd0, expv[63:32]});
    end

    // Randomised prescale / start value / wait against the arithmetic model
    for (int it = 0; it < 6; it++) begin
      p = int'($urandom_range(0, 7));
      base = {$urandom, $urandom};
      wt = int'($urandom_range(5, 50));
      wr(3'd4, 32'd0); wr(3'd5, 32'(p)); wr(3'd0, base[31:0]); wr(3'd1, base[63:32]);
      wr(3'd4, 32'd1); en_edge = last_edge;
      repeat (wt) @(posedge clk);
      rd(3'd0, v); expv = mt_at(base, en_edge, last_edge, p);
      rd(3'd1, v2);
      chk($sformatf("rnd%0d_lo", it), {32'd0, v}, {32'd0, expv[31:0]});
      chk($sformatf("rnd%0d_hi", it), {32'd0, v2}, {32'd0, expv[63:32]});
    end

    // Interrupt rises one cycle after mtime reaches 20, falls after cmp raise
    wr(3'd4, 32'd0); wr(3'd5, 32'd0); wr(3'd0, 32'd0); wr(3'd1, 32'd0);
    wr(3'd3, 32'd0); wr(3'd2, 32'd20);
    wr(3'd4, 32'd3); en_edge = last_edge;
    for (int c = 0; c < 30; c++) begin
      expv = mt_at(64'd0, en_edge, ncyc, 0);
      chk($sformatf("irq_t%0d", c), {63'd0, irq}, {63'd0, expv >= 64'd20});
      @(posedge clk); #1;
    end
    wr(3'd2, 32'd100);
    chk("irq_cleared", {63'd0, irq}, 64'd0);

    // Partial-byte LO write coinciding with a tick: write wins, no increment
    wr(3'd4, 32'd0); wr(3'd5, 32'd2); wr(3'd0, 32'h100); wr(3'd1, 32'd0);
    wr(3'd4, 32'd1); en_edge = last_edge;
    bus(3'd0, 1'b1, 32'h0000_00AA, 4'b0001, v, k, e); w_edge = last_edge;
    pre = mt_at(64'h100, en_edge, w_edge, 2);
    base = {pre[63:8], 8'hAA};
    rd(3'd0, v);
    expv = base + 64'((last_edge - 1 - en_edge) / 3 - (w_edge - en_edge) / 3);
    chk("sel_tick_model", {32'd0, v}, expv);
    chk("sel_tick_plan", {32'd0, v}, 64'h1AA);

    // Reset during a pending ack with irq high
    wr(3'd3, 32'd0); wr(3'd2, 32'd0); wr(3'd4, 32'd3);
    repeat (3) @(posedge clk);
    #1;
    chk("irq_pre_reset", {63'd0, irq}, 64'd1);
    @(posedge clk); #1;
    adr = 3'd0; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    chk("ack_pending", {63'd0, ack}, 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_outputs", {30'd0, dat_o, ack, err, irq}, 64'd0);
    cyc = 1'b0; stb = 1'b0; rst = 1'b0;
    rd(3'd0, v);
    chk("rst_mtime", {32'd0, v}, 64'd0);
    rd(3'd4, v);
    chk("rst_ctrl", {32'd0, v}, 64'd0);
    rd(3'd2, v);
    chk("rst_cmp_lo", {32'd0, v}, 64'hFFFF_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
